text_term_writer: RTL and testbench
===================================

// Module: text_term_writer
// PURPOSE
//   Character terminal front-end for the 20x15 text display. Accepts a byte stream
//   (CPU/UART) over a valid/ready handshake, tracks a cursor, interprets control codes
//   and issues single-byte writes to the video RAM write port (vidData/vidAdrs/vidWE).
//   Sits directly upstream of the dvi block and drives its write inputs.
// PARAMETERS
//   COLS           20     characters per row (640/32)
//   ROWS           15     rows per screen (480/32)
//   FILL           8'h20  byte written when clearing (space)
//   CLEAR_ON_RESET 1      1: clear whole screen after reset release; 0: start in IDLE
// PORTS
//   clk        in   1  system clock (same domain as video RAM write port)
//   rst_n      in   1  asynchronous active-low reset
//   in_data    in   8  character/control byte
//   in_valid   in   1  in_data valid
//   in_ready   out  1  block can accept a byte this cycle
//   vidData    out  8  video RAM write data
//   vidAdrs    out  9  video RAM write address = row*COLS + col (0..299)
//   vidWE      out  1  video RAM write strobe, one cycle per byte
//   cur_col    out  5  cursor column 0..COLS-1
//   cur_row    out  4  cursor row 0..ROWS-1
//   busy       out  1  a multi-cycle clear/tab sequence is in progress
// BEHAVIOUR
//   Reset: vidWE=0, vidAdrs=0, vidData=FILL, cur_col=0, cur_row=0;
//     state=INIT_CLEAR (in_ready=0, busy=1) if CLEAR_ON_RESET, else IDLE (in_ready=1, busy=0).
//   Reset asserted mid-sequence aborts immediately; no partial state survives.
//   All outputs registered. Byte accepted on in_valid&in_ready; in_ready=1 only in IDLE.
//   Write latency: vidWE high exactly in the cycle after acceptance.
//   States: IDLE, CLEAR_LINE, CLEAR_SCREEN (INIT_CLEAR uses CLEAR_SCREEN), TAB.
//   Printable 0x20..0x7E: write byte at (row,col); col+1. If col was COLS-1:
//     col=0, row+1 (ROWS-1 wraps to 0), then CLEAR_LINE on the new row.
//   0x0A LF: col=0, row+1 with the same wrap, then CLEAR_LINE. No write in accept cycle.
//   0x0D CR: col=0; no write; stays IDLE.
//   0x08 BS: col>0: col-1 and write FILL at new position; col=0: no-op (no row change).
//   0x0C FF: CLEAR_SCREEN, addresses 0..COLS*ROWS-1 ascending, one per cycle;
//     cursor set to (0,0) on completion.
//   Any other byte: accepted and dropped, no write (charrom has no glyph below 0x20).
//   CLEAR_LINE: COLS consecutive writes of FILL at row*COLS..row*COLS+COLS-1, then IDLE.
//   CLEAR_SCREEN: 300 writes; busy=1 throughout; IDLE on the cycle after the last write.
//   No scrolling: the write port is write-only; wrap to row 0 and clear it instead.
//   Address arithmetic: row*COLS computed in 9 bits; max 299, never exceeds 9'd299.
//   in_valid held while in_ready=0 is not consumed; the byte is taken once IDLE returns.
// CONFIGURATION
//   TEXT_TERM_TAB_EN defined: 0x09 TAB enters TAB state, writes FILL at successive
//     columns until col is a multiple of 4; if this reaches COLS it wraps as for the
//     last column (newline + CLEAR_LINE). At col%4==0 TAB still advances a full 4.
//   Undefined: 0x09 is treated as an unhandled control byte (accepted, dropped).
// TESTING
//   Reset, CLEAR_ON_RESET=1 -> 300 FILL writes at 0..299, then in_ready=1, cursor (0,0).
//   Send 'A'(0x41) at (0,0) -> next cycle vidWE=1, vidAdrs=0, vidData=0x41; cur_col=1.
//   21 printables from (0,0) -> 20th at addr 19, 20 FILL writes at 20..39, 21st at addr 20.
//   Cursor (14,5), LF -> cur_row=0, cur_col=0, FILL writes at 0..19; in_ready low 20+ cycles.
//   BS at (3,0) -> no write; BS at (3,7) -> FILL at 3*20+6=66, cur_col=6.
//   FF mid-screen, rst_n pulsed low at write 150 -> outputs reset, clear restarts at 0.
//   TEXT_TERM_TAB_EN, TAB at col 5 -> FILL at cols 5,6,7; cur_col=8. TAB at col 18 -> wrap.

Source files
------------

// File: rtl/text_term_writer_if.sv
// Byte-stream handshake between a character source (CPU/UART) and the terminal writer.
//   in_data  : character/control byte, source -> writer
//   in_valid : in_data valid, source -> writer
//   in_ready : writer can accept a byte this cycle, writer -> source
interface text_term_writer_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input  in_ready);
  modport slave  (input  in_data, input  in_valid, output in_ready);
endinterface

// File: rtl/text_term_writer.sv
// Character terminal front-end for the 20x15 text display. Takes bytes over a
// valid/ready stream, tracks the cursor, interprets control codes and issues
// single-byte writes to the video RAM write port.
// Optional feature macro: TEXT_TERM_TAB_EN (0x09 advances to the next 4-column stop).
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   in_if       : byte stream (slave side: in_data, in_valid, in_ready)
//   vidData     : video RAM write data
//   vidAdrs     : video RAM write address, row*COLS + col
//   vidWE       : video RAM write strobe, one cycle per byte
//   cur_col     : cursor column
//   cur_row     : cursor row
//   busy        : multi-cycle clear/tab sequence in progress
module text_term_writer #(
  parameter int unsigned COLS           = 20,
  parameter int unsigned ROWS           = 15,
  parameter logic [7:0]  FILL           = 8'h20,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  text_term_writer_if.slave    in_if,
  output logic [7:0]           vidData,
  output logic [8:0]           vidAdrs,
  output logic                 vidWE,
  output logic [4:0]           cur_col,
  output logic [3:0]           cur_row,
  output logic                 busy
);

  localparam int unsigned AW = 9;
  localparam int unsigned CW = 5;
  localparam int unsigned RW = 4;
  localparam int unsigned DW = 8;

  typedef enum logic [1:0] {IDLE, CLEAR_LINE, CLEAR_SCREEN, TAB} state_t;

  localparam state_t RST_STATE = CLEAR_ON_RESET ? CLEAR_SCREEN : IDLE;

  state_t        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] adrs_q, adrs_d;
  logic [DW-1:0] data_q, data_d;
  logic          we_q, we_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;

  logic          accept;
  logic          last_col;
  logic [RW-1:0] nrow;
  logic [AW-1:0] row_base;
  logic [AW-1:0] nrow_base;
  logic [AW-1:0] cur_adr;

  // Cursor-derived addresses; the next row wraps to 0 since there is no scrolling.
  always_comb begin
    accept    = in_if.in_valid & ready_q;
    last_col  = (col_q == CW'(COLS - 1));
    nrow      = (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
    row_base  = AW'(AW'(row_q) * AW'(COLS));
    nrow_base = AW'(AW'(nrow) * AW'(COLS));
    cur_adr   = AW'(row_base + AW'(col_q));
  end

  // Next-state and write-port logic.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    adrs_d  = adrs_q;
    data_d  = data_q;
    we_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (in_if.in_data >= 8'h20 && in_if.in_data <= 8'h7E) begin
            we_d   = 1'b1;
            adrs_d = cur_adr;
            data_d = in_if.in_data;
            if (last_col) begin
              col_d   = '0;
              row_d   = nrow;
              cnt_d   = nrow_base;
              state_d = CLEAR_LINE;
            end else begin
              col_d = col_q + CW'(1);
            end
          end else begin
            case (in_if.in_data)
              8'h0A: begin
                col_d   = '0;
                row_d   = nrow;
                cnt_d   = nrow_base;
                state_d = CLEAR_LINE;
              end
              8'h0D: col_d = '0;
              8'h08: begin
                if (col_q != '0) begin
                  col_d  = col_q - CW'(1);
                  we_d   = 1'b1;
                  adrs_d = AW'(cur_adr - AW'(1));
                  data_d = FILL;
                end
              end
              8'h0C: begin
                cnt_d   = '0;
                state_d = CLEAR_SCREEN;
              end
`ifdef TEXT_TERM_TAB_EN
              8'h09: state_d = TAB;
`endif
              default: ;
            endcase
          end
        end
      end

      CLEAR_LINE: begin
        we_d   = 1'b1;
        adrs_d = cnt_q;
        data_d = FILL;
        cnt_d  = cnt_q + AW'(1);
        if (cnt_q == AW'(row_base + AW'(COLS - 1))) state_d = IDLE;
      end

      CLEAR_SCREEN: begin
        we_d   = 1'b1;
        adrs_d = cnt_q;
        data_d = FILL;
        cnt_d  = cnt_q + AW'(1);
        if (cnt_q == AW'(COLS * ROWS - 1)) begin
          state_d = IDLE;
          col_d   = '0;
          row_d   = '0;
        end
      end

      TAB: begin
`ifdef TEXT_TERM_TAB_EN
        // One FILL per cycle; stop once the cursor lands on a multiple of 4.
        we_d   = 1'b1;
        adrs_d = cur_adr;
        data_d = FILL;
        if (last_col) begin
          col_d   = '0;
          row_d   = nrow;
          cnt_d   = nrow_base;
          state_d = CLEAR_LINE;
        end else begin
          col_d = col_q + CW'(1);
          if (col_q[1:0] == 2'b11) state_d = IDLE;
        end
`else
        state_d = IDLE;
`endif
      end

      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RST_STATE;
      col_q   <= '0;
      row_q   <= '0;
      cnt_q   <= '0;
      adrs_q  <= '0;
      data_q  <= FILL;
      we_q    <= 1'b0;
      ready_q <= !CLEAR_ON_RESET;
      busy_q  <= CLEAR_ON_RESET;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      adrs_q  <= adrs_d;
      data_q  <= data_d;
      we_q    <= we_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign in_if.in_ready = ready_q;
  assign vidData        = data_q;
  assign vidAdrs        = adrs_q;
  assign vidWE          = we_q;
  assign cur_col        = col_q;
  assign cur_row        = row_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_text_term_writer.sv
// Directed bench for text_term_writer: reset clear, printables, line wrap,
// LF/CR/BS/FF, dropped bytes, optional TAB, and reset during a screen clear.
module tb_text_term_writer;

  logic       clk;
  logic       rst_n;
  logic [7:0] vidData;
  logic [8:0] vidAdrs;
  logic       vidWE;
  logic [4:0] cur_col;
  logic [3:0] cur_row;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;
  int exp_col;
  int exp_row;

  text_term_writer_if tif ();

  text_term_writer dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_if   (tif),
    .vidData (vidData),
    .vidAdrs (vidAdrs),
    .vidWE   (vidWE),
    .cur_col (cur_col),
    .cur_row (cur_row),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input int adr, input logic [7:0] d);
    chk("write", {14'd0, vidWE, vidAdrs, vidData}, {14'd0, 1'b1, 9'(adr), d});
  endtask

  task automatic chk_nowr();
    chk("no_write", {31'd0, vidWE}, 32'd0);
  endtask

  task automatic chk_cur(input int c, input int r);
    chk("cursor", {23'd0, cur_row, cur_col}, {23'd0, 4'(r), 5'(c)});
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    tif.in_data  = b;
    tif.in_valid = 1'b1;
    while (tif.in_ready !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) chk("send_timeout", 32'(n), 32'd0);
    @(negedge clk);
    tif.in_valid = 1'b0;
  endtask

  // Checks n consecutive FILL writes from base; ends at the negedge of the last one.
  task automatic expect_clear(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      chk_wr(base + i, 8'h20);
      chk("clear_ready", {31'd0, tif.in_ready}, 32'(i == n - 1));
      if (i != n - 1) @(negedge clk);
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    tif.in_data  = 8'h00;
    tif.in_valid = 1'b0;
    repeat (2) @(negedge clk);

    // Reset values
    chk("rst_out", {14'd0, vidWE, vidAdrs, vidData}, {14'd0, 1'b0, 9'd0, 8'h20});
    chk_cur(0, 0);
    chk("rst_ready_busy", {30'd0, tif.in_ready, busy}, {30'd0, 1'b0, 1'b1});

    // Clear-on-reset: 300 FILL writes 0..299
    rst_n = 1'b1;
    @(negedge clk);
    expect_clear(0, 300);
    chk("init_done", {30'd0, tif.in_ready, busy}, {30'd0, 1'b1, 1'b0});
    chk_cur(0, 0);

    // 'A' at (0,0)
    send(8'h41);
    chk_wr(0, 8'h41);
    chk_cur(1, 0);

    // CR back to column 0
    send(8'h0D);
    chk_nowr();
    chk_cur(0, 0);

    // 21 printables: 20th at 19, line 1 cleared, 21st at 20
    for (int i = 0; i < 20; i++) begin
      send(8'(8'h61 + i));
      chk_wr(i, 8'(8'h61 + i));
    end
    chk_cur(0, 1);
    chk("wrap_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    expect_clear(20, 20);
    send(8'h75);
    chk_wr(20, 8'h75);
    chk_cur(1, 1);

    // LF down to row 14, each clearing its new row
    for (int r = 2; r <= 14; r++) begin
      send(8'h0A);
      chk_nowr();
      chk_cur(0, r);
      @(negedge clk);
      expect_clear(r * 20, 20);
    end
    for (int i = 0; i < 5; i++) begin
      send(8'(8'h30 + i));
      chk_wr(280 + i, 8'(8'h30 + i));
    end
    chk_cur(5, 14);

    // LF on the last row wraps to row 0 and clears it
    send(8'h0A);
    chk_nowr();
    chk_cur(0, 0);
    chk("lf_ready_low", {31'd0, tif.in_ready}, 32'd0);
    @(negedge clk);
    expect_clear(0, 20);

    // BS at column 0 is a no-op
    send(8'h08);
    chk_nowr();
    chk_cur(0, 0);

    // Down to row 3; 'Q' held valid during the clear is taken once afterwards
    send(8'h0A); @(negedge clk); expect_clear(20, 20);
    send(8'h0A); @(negedge clk); expect_clear(40, 20);
    send(8'h0A);
    chk_nowr();
    tif.in_data  = 8'h51;
    tif.in_valid = 1'b1;
    @(negedge clk);
    expect_clear(60, 20);
    @(negedge clk);
    chk_wr(60, 8'h51);
    tif.in_valid = 1'b0;
    chk_cur(1, 3);
    @(negedge clk);
    chk_nowr();

    // To (3,7) then BS -> FILL at 66
    for (int i = 0; i < 6; i++) begin
      send(8'(8'h62 + i));
      chk_wr(61 + i, 8'(8'h62 + i));
    end
    chk_cur(7, 3);
    send(8'h08);
    chk_wr(66, 8'h20);
    chk_cur(6, 3);

    // Unhandled control byte dropped
    send(8'h01);
    chk_nowr();
    chk_cur(6, 3);
    chk("drop_ready", {31'd0, tif.in_ready}, 32'd1);

`ifdef TEXT_TERM_TAB_EN
    // TAB from col 6 -> FILL at 6,7; col 8
    send(8'h09);
    chk_nowr();
    @(negedge clk); chk_wr(66, 8'h20);
    @(negedge clk); chk_wr(67, 8'h20);
    chk_cur(8, 3);
    chk("tab_ready", {31'd0, tif.in_ready}, 32'd1);
    // TAB at a stop advances a full 4
    send(8'h09);
    chk_nowr();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_wr(68 + i, 8'h20);
    end
    chk_cur(12, 3);
    for (int i = 0; i < 6; i++) begin
      send(8'(8'h63 + i));
      chk_wr(72 + i, 8'(8'h63 + i));
    end
    // TAB at col 18 wraps to the next line and clears it
    send(8'h09);
    chk_nowr();
    @(negedge clk); chk_wr(78, 8'h20);
    @(negedge clk); chk_wr(79, 8'h20);
    chk_cur(0, 4);
    @(negedge clk);
    expect_clear(80, 20);
    exp_col = 0;
    exp_row = 4;
`else
    // Without the tab feature 0x09 is dropped
    send(8'h09);
    chk_nowr();
    chk_cur(6, 3);
    @(negedge clk);
    chk_nowr();
    exp_col = 6;
    exp_row = 3;
`endif

    // FF, then reset during write 150
    send(8'h0C);
    chk_nowr();
    chk("ff_busy", {30'd0, tif.in_ready, busy}, {30'd0, 1'b0, 1'b1});
    @(negedge clk);
    for (int i = 0; i < 150; i++) begin
      chk_wr(i, 8'h20);
      @(negedge clk);
    end
    chk_cur(exp_col, exp_row);
    rst_n = 1'b0;
    #1;
    chk("midrst_out", {14'd0, vidWE, vidAdrs, vidData}, {14'd0, 1'b0, 9'd0, 8'h20});
    chk_cur(0, 0);
    chk("midrst_ready_busy", {30'd0, tif.in_ready, busy}, {30'd0, 1'b0, 1'b1});
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    expect_clear(0, 300);
    chk_cur(0, 0);

    send(8'h5A);
    chk_wr(0, 8'h5A);
    chk_cur(1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
